// File: rtl/branch_predictor.sv
// Dynamic branch predictor with a direct-mapped branch target buffer.
// IF side : pc_i is looked up combinationally; pred_taken_o / pred_pc_o
//           feed the PC-select mux with zero latency.
// ID side : the prediction is shadowed alongside IF/ID and compared with the
//           resolution of the instruction in ID; a mismatch raises
//           mispredict_o with the corrected PC on redirect_pc_o.
// Update  : saturating counters and targets are trained from resolved
//           branches; branch and mispredict totals are kept as statistics.
// Ports   : clk_i, rst_i (sync, active-high); pc_i, pred_taken_o, pred_pc_o;
//           stall_i, flush_i; res_valid_i, res_taken_i, res_target_i;
//           mispredict_o, redirect_pc_o; branch_cnt_o, mispredict_cnt_o.
module branch_predictor #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_pc_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              res_valid_i,
    input  logic              res_taken_i,
    input  logic [ADDR_W-1:0] res_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    btb_entry_t btb_q [ENTRIES];

    logic              id_valid_q, id_pred_taken_q;
    logic [ADDR_W-1:0] id_pc_q, id_pred_pc_q;
    logic [CNT_W-1:0]  branch_cnt_q, mispredict_cnt_q;

    // IF lookup: taken when the entry hits and the counter MSB is set.
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    btb_entry_t        if_entry;
    logic              if_pred_taken;
    logic [ADDR_W-1:0] if_pred_pc;

    always_comb begin
        if_idx        = pc_i[IDX_W+1:2];
        if_tag        = pc_i[ADDR_W-1:IDX_W+2];
        if_entry      = btb_q[if_idx];
        if_pred_taken = !rst_i && if_entry.valid && (if_entry.tag == if_tag)
                        && if_entry.ctr[CTR_W-1];
        if_pred_pc    = if_pred_taken ? if_entry.target : pc_i + ADDR_W'(4);
    end

    assign pred_taken_o = if_pred_taken;
    assign pred_pc_o    = if_pred_pc;

    // ID resolution: a stalled ID instruction is not yet final, so it neither
    // mispredicts nor trains; it resolves again once the stall drops.
    logic              act;
    logic [ADDR_W-1:0] id_pc_plus4, actual_pc;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    always_comb begin
        act         = id_valid_q && !stall_i && !rst_i;
        id_pc_plus4 = id_pc_q + ADDR_W'(4);
        actual_pc   = res_taken_i ? res_target_i : id_pc_plus4;
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (act) begin
            // A predicted-taken non-branch is an aliased BTB hit.
            mispredict = res_valid_i ? (actual_pc != id_pred_pc_q) : id_pred_taken_q;
        end
        if (mispredict) begin
            redirect_pc = res_valid_i ? actual_pc : id_pc_plus4;
        end
    end

    assign mispredict_o  = mispredict;
    assign redirect_pc_o = redirect_pc;

    // BTB training for the instruction in ID, based on current contents.
    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    btb_entry_t       id_entry, upd_entry_d;
    logic             id_hit, upd_we;

    always_comb begin
        id_idx      = id_pc_q[IDX_W+1:2];
        id_tag      = id_pc_q[ADDR_W-1:IDX_W+2];
        id_entry    = btb_q[id_idx];
        id_hit      = id_entry.valid && (id_entry.tag == id_tag);
        upd_entry_d = id_entry;
        upd_we      = 1'b0;
        if (act) begin
            if (res_valid_i) begin
                if (id_hit) begin
                    upd_we = 1'b1;
                    if (res_taken_i) begin
                        upd_entry_d.target = res_target_i;
                        if (id_entry.ctr != CTR_MAX) begin
                            upd_entry_d.ctr = id_entry.ctr + CTR_W'(1);
                        end
                    end else if (id_entry.ctr != '0) begin
                        upd_entry_d.ctr = id_entry.ctr - CTR_W'(1);
                    end
                end else if (res_taken_i) begin
                    upd_we             = 1'b1;
                    upd_entry_d.valid  = 1'b1;
                    upd_entry_d.tag    = id_tag;
                    upd_entry_d.target = res_target_i;
                    upd_entry_d.ctr    = CTR_WEAK_T;
                end
            end else if (id_pred_taken_q) begin
                upd_we            = 1'b1;
                upd_entry_d.valid = 1'b0;
            end
        end
    end

    // BTB storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
        end else if (upd_we) begin
            btb_q[id_idx] <= upd_entry_d;
        end
    end

    // IF/ID shadow of the prediction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_valid_q      <= 1'b0;
            id_pred_taken_q <= 1'b0;
            id_pc_q         <= '0;
            id_pred_pc_q    <= '0;
        end else if (flush_i || mispredict) begin
            id_valid_q      <= 1'b0;
            id_pred_taken_q <= 1'b0;
        end else if (!stall_i) begin
            id_valid_q      <= 1'b1;
            id_pred_taken_q <= if_pred_taken;
            id_pc_q         <= pc_i;
            id_pred_pc_q    <= if_pred_pc;
        end
    end

    // Statistics, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (act && res_valid_i) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
        end
    end

    assign branch_cnt_o     = rst_i ? '0 : branch_cnt_q;
    assign mispredict_cnt_o = rst_i ? '0 : mispredict_cnt_q;

endmodule
